// File: rtl/tank_timer_pkg.sv
// Shared definitions for the tank timer family: state encoding, default sizing
// and the prescaler width helper.
package tank_timer_pkg;

    typedef enum logic {
        ST_READY    = 1'b0,
        ST_COOLDOWN = 1'b1
    } timer_state_e;

    localparam int                   DEF_WIDTH    = 5;
    localparam int                   DEF_PRESCALE = 4;
    localparam logic [DEF_WIDTH-1:0] DEF_RELOAD   = 5'd20;

    // A divide-by-1 prescaler still needs one bit to hold its (constant) zero.
    function automatic int prescale_width(input int prescale);
        return (prescale > 1) ? $clog2(prescale) : 1;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides enabled clocks by PRESCALE; tick is high on the enabled clock that
// completes each group of PRESCALE clocks.
module tick_prescaler
    import tank_timer_pkg::*;
#(
    parameter int PRESCALE = DEF_PRESCALE
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int              PW   = prescale_width(PRESCALE);
    localparam logic [PW-1:0]   LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] prescaler;

    assign tick = enable && (prescaler == LAST);

    // clear wins over enable so a fresh cooldown always starts a full period.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prescaler <= '0;
        end else if (clear) begin
            prescaler <= '0;
        end else if (enable) begin
            if (tick) begin
                prescaler <= '0;
            end else begin
                prescaler <= prescaler + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fire_cooldown_timer.sv
// Gates tank fire requests: grants one fire, then blocks further fires for
// reload_reg prescaled ticks before re-arming.
module fire_cooldown_timer
    import tank_timer_pkg::*;
#(
    parameter int               WIDTH    = DEF_WIDTH,
    parameter int               PRESCALE = DEF_PRESCALE,
    parameter logic [WIDTH-1:0] RELOAD   = WIDTH'(DEF_RELOAD)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             fire_req,
    input  logic             load,
    input  logic [WIDTH-1:0] reload_value,
    output logic             fire_grant,
    output logic             ready,
    output logic             expired,
    output logic [WIDTH-1:0] count
);

    // Handshake: a fire is accepted on any clock edge where enable, ready and
    // fire_req are all 1; fire_grant is high for the cycle after that edge.
    // fire_req while ready is 0 is dropped, never queued.

    timer_state_e     state;
    timer_state_e     state_next;
    logic [WIDTH-1:0] count_next;
    logic [WIDTH-1:0] reload_reg;
    logic [WIDTH-1:0] reload_next;
    logic [WIDTH-1:0] cooldown_value;
    logic             grant_next;
    logic             expired_next;
    logic             tick;
    logic             prescale_clear;

    // Holding the prescaler clear in READY means the grant edge starts it at 0.
    assign prescale_clear = (state == ST_READY);
    assign cooldown_value = load ? reload_value : reload_reg;
    assign ready          = (state == ST_READY);

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .clear  (prescale_clear),
        .tick   (tick)
    );

    always_comb begin
        state_next   = state;
        count_next   = count;
        grant_next   = 1'b0;
        expired_next = 1'b0;
        reload_next  = load ? reload_value : reload_reg;

        if (enable) begin
            case (state)
                ST_READY: begin
                    if (fire_req) begin
                        grant_next = 1'b1;
                        // A zero-length cooldown grants but never leaves READY.
                        if (cooldown_value != '0) begin
                            count_next = cooldown_value;
                            state_next = ST_COOLDOWN;
                        end
                    end
                end
                ST_COOLDOWN: begin
                    if (count == '0) begin
                        state_next = ST_READY;
                    end else if (tick) begin
                        count_next = count - 1'b1;
                        if (count == WIDTH'(1)) begin
                            expired_next = 1'b1;
                            state_next   = ST_READY;
                        end
                    end
                end
                default: begin
                    state_next = ST_READY;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_READY;
            count      <= '0;
            reload_reg <= RELOAD;
            fire_grant <= 1'b0;
            expired    <= 1'b0;
        end else begin
            state      <= state_next;
            count      <= count_next;
            reload_reg <= reload_next;
            fire_grant <= grant_next;
            expired    <= expired_next;
        end
    end

endmodule

// File: tb/tb_fire_cooldown_timer.sv
// Directed bench for fire_cooldown_timer with a cycle-level reference model
// compared against the outputs after every clock edge.
module tb_fire_cooldown_timer;

    localparam int               WIDTH    = 5;
    localparam int               PRESCALE = 2;
    localparam logic [WIDTH-1:0] RELOAD   = 5'd3;

    logic             clock        = 1'b0;
    logic             reset        = 1'b0;
    logic             enable       = 1'b0;
    logic             fire_req     = 1'b0;
    logic             load         = 1'b0;
    logic [WIDTH-1:0] reload_value = '0;
    logic             fire_grant;
    logic             ready;
    logic             expired;
    logic [WIDTH-1:0] count;

    int errors = 0;
    int checks = 0;
    int n;
    int last_grant;
    int grant_total;

    fire_cooldown_timer #(
        .WIDTH    (WIDTH),
        .PRESCALE (PRESCALE),
        .RELOAD   (RELOAD)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .fire_req     (fire_req),
        .load         (load),
        .reload_value (reload_value),
        .fire_grant   (fire_grant),
        .ready        (ready),
        .expired      (expired),
        .count        (count)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    // Cooldown is tracked as "enabled edges elapsed since the grant"; the
    // visible count is the reload length minus completed prescale periods.
    typedef struct {
        bit busy;
        int len;
        int elapsed;
        int reload;
        bit grant;
        bit expired;
    } model_t;

    model_t m;

    function automatic model_t model_reset();
        model_t r;
        r.busy    = 1'b0;
        r.len     = 0;
        r.elapsed = 0;
        r.reload  = int'(RELOAD);
        r.grant   = 1'b0;
        r.expired = 1'b0;
        return r;
    endfunction

    function automatic model_t model_next(input model_t c, input logic en,
                                          input logic fr, input logic ld,
                                          input logic [WIDTH-1:0] rv);
        model_t nx;
        int     v;
        nx         = c;
        nx.grant   = 1'b0;
        nx.expired = 1'b0;
        if (ld) nx.reload = int'(rv);
        if (en) begin
            if (c.busy) begin
                nx.elapsed = c.elapsed + 1;
                if (nx.elapsed == c.len * PRESCALE) begin
                    nx.busy    = 1'b0;
                    nx.expired = 1'b1;
                end
            end else if (fr) begin
                nx.grant = 1'b1;
                v = ld ? int'(rv) : c.reload;
                if (v > 0) begin
                    nx.busy    = 1'b1;
                    nx.len     = v;
                    nx.elapsed = 0;
                end
            end
        end
        return nx;
    endfunction

    function automatic int model_count(input model_t c);
        return c.busy ? (c.len - c.elapsed / PRESCALE) : 0;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) m <= model_reset();
        else        m <= model_next(m, enable, fire_req, load, reload_value);
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clock) begin
        #1;
        check("model_grant",   int'(fire_grant), int'(m.grant));
        check("model_expired", int'(expired),    int'(m.expired));
        check("model_ready",   int'(ready),      int'(!m.busy));
        check("model_count",   int'(count),      model_count(m));
    end

    // ---------------- driver tasks ----------------
    // Returns 2 time units after the rising edge; inputs change only here.
    task automatic clk();
        @(posedge clock);
        #2;
    endtask

    task automatic wait_ready(input int budget, input string name);
        int k;
        k = 0;
        while (!ready && k < budget) begin
            clk();
            k++;
        end
        check(name, int'(ready), 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset and idle
        repeat (2) clk();
        check("rst_count",   int'(count),      0);
        check("rst_ready",   int'(ready),      1);
        check("rst_grant",   int'(fire_grant), 0);
        check("rst_expired", int'(expired),    0);
        reset  = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            clk();
            check("idle_ready", int'(ready), 1);
            check("idle_count", int'(count), 0);
        end

        // Single fire with RELOAD=3, PRESCALE=2
        fire_req = 1'b1;
        clk();
        fire_req = 1'b0;
        check("single_grant", int'(fire_grant), 1);
        check("single_count", int'(count),      3);
        check("single_ready", int'(ready),      0);
        clk();
        check("single_grant_off", int'(fire_grant), 0);
        check("single_count_p1",  int'(count),      3);
        clk();
        check("single_count_p2", int'(count), 2);
        repeat (2) clk();
        check("single_count_p4", int'(count), 1);
        clk();
        check("single_expired_p5", int'(expired), 0);
        clk();
        check("single_count_p6",   int'(count),   0);
        check("single_expired_p6", int'(expired), 1);
        check("single_ready_p6",   int'(ready),   1);
        clk();
        check("single_expired_p7", int'(expired), 0);

        // Held fire_req: grants 7 clocks apart
        last_grant  = -1;
        grant_total = 0;
        fire_req    = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            clk();
            if (fire_grant) begin
                if (last_grant >= 0) check("held_gap", i - last_grant, 7);
                last_grant = i;
                grant_total++;
            end
        end
        fire_req = 1'b0;
        check("held_grant_total", grant_total, 3);
        wait_ready(20, "held_rearm");

        // Freeze for 4 cycles at count=2
        fire_req = 1'b1;
        clk();
        fire_req = 1'b0;
        repeat (2) clk();
        check("freeze_count_start", int'(count), 2);
        enable = 1'b0;
        repeat (4) begin
            clk();
            check("freeze_count_hold", int'(count), 2);
        end
        enable = 1'b1;
        n = 6;
        do begin
            clk();
            n++;
        end while (!expired && n < 40);
        check("freeze_expiry_edge", n, 10);

        // Asynchronous reset mid-cooldown
        fire_req = 1'b1;
        clk();
        fire_req = 1'b0;
        repeat (2) clk();
        check("areset_count_before", int'(count), 2);
        reset = 1'b0;
        #1;
        check("areset_count", int'(count), 0);
        check("areset_ready", int'(ready), 1);
        clk();
        reset = 1'b1;
        clk();
        check("areset_ready_after", int'(ready), 1);
        check("areset_count_after", int'(count), 0);

        // Load during cooldown does not disturb it
        fire_req = 1'b1;
        clk();
        fire_req = 1'b0;
        check("reload_mid_start", int'(count), 3);
        load         = 1'b1;
        reload_value = 5'd31;
        clk();
        load = 1'b0;
        n    = 1;
        do begin
            clk();
            n++;
        end while (!expired && n < 40);
        check("reload_mid_expiry_edge", n, 6);
        fire_req = 1'b1;
        clk();
        fire_req = 1'b0;
        check("reload_31_grant", int'(fire_grant), 1);
        check("reload_31_count", int'(count),      31);
        wait_ready(80, "reload_31_rearm");

        // Load on the same edge as an accepted fire
        load         = 1'b1;
        reload_value = 5'd5;
        fire_req     = 1'b1;
        clk();
        load     = 1'b0;
        fire_req = 1'b0;
        check("reload_same_grant", int'(fire_grant), 1);
        check("reload_same_count", int'(count),      5);
        wait_ready(20, "reload_same_rearm");

        // Zero-length cooldown
        load         = 1'b1;
        reload_value = 5'd0;
        clk();
        load     = 1'b0;
        fire_req = 1'b1;
        clk();
        check("zero_grant",   int'(fire_grant), 1);
        check("zero_ready",   int'(ready),      1);
        check("zero_count",   int'(count),      0);
        check("zero_expired", int'(expired),    0);
        clk();
        check("zero_regrant", int'(fire_grant), 1);
        fire_req = 1'b0;
        clk();
        check("zero_grant_off",   int'(fire_grant), 0);
        check("zero_expired_off", int'(expired),    0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fire_cooldown_timer.md
Name: fire_cooldown_timer

Overview:
- Loadable down-counter that gates tank fire requests. It is the count-down counterpart of the team's 5-bit up-counter.
- On an accepted fire request it issues a one-cycle grant, loads the cooldown value, and counts down to 0 at a prescaled rate. It re-arms when the count reaches 0.
- Sits between the player input logic and the projectile spawner. One instance per tank.

Parameters:
- WIDTH, 5, bit width of the count and the reload value.
- PRESCALE, 4, enabled clocks per count decrement; must be >= 1.
- RELOAD, 5'd20, reset value of the reload register.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset; 0 clears all state immediately.
- enable  in  1  1 = timer runs and accepts fires; 0 = freeze all state.
- fire_req  in  1  level request to fire, sampled each edge.
- load  in  1  write reload_value into the reload register.
- reload_value  in  WIDTH  new cooldown length, in ticks.
- fire_grant  out  1  one-cycle registered pulse: fire accepted.
- ready  out  1  1 = in READY state, can accept a fire.
- expired  out  1  one-cycle pulse when the count reaches 0 from cooldown.
- count  out  WIDTH  remaining cooldown ticks.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=READY, count=0, prescaler=0, reload_reg=RELOAD.
  - fire_grant=0, expired=0, ready=1.
  - Reset mid-cooldown aborts the cooldown at once. Normal operation resumes on the first edge after reset returns high.
- All outputs are registered. fire_grant and expired are 0 on every cycle unless stated below.
- State machine: two states, READY and COOLDOWN.
- READY, enable=1, fire_req=1:
  - fire_grant=1 for one cycle; prescaler=0.
  - Cooldown value V = reload_value if load=1 this edge, else reload_reg.
  - V>0: count=V, state=COOLDOWN, ready=0.
  - V=0: count stays 0, state stays READY, ready stays 1, no expired pulse.
- COOLDOWN, enable=1, each edge:
  - prescaler increments.
  - When prescaler==PRESCALE-1: prescaler=0 and count decrements by 1 (a "tick").
  - Tick taking count from 1 to 0: expired=1 for one cycle, state=READY, ready=1 on the same edge.
- COOLDOWN, fire_req=1: ignored. No queueing, no grant.
- enable=0: state, count and prescaler hold. fire_req is not accepted. No pulses are generated.
- Timing with reload R>0:
  - count reaches 0 exactly R*PRESCALE enabled edges after the grant edge.
  - fire_req held high gives grants spaced R*PRESCALE+1 clocks apart.
- load=1 (any state, enable ignored):
  - reload_reg=reload_value on that edge.
  - An in-progress cooldown is unaffected.
- Arithmetic:
  - count saturates at 0 and never wraps below 0.
  - Prescaler width is max(1, clog2(PRESCALE)).
  - PRESCALE=1 gives a tick on every enabled edge.

Decomposition:
- Shared package tank_timer_pkg holds:
  - state encoding constants (ST_READY=1'b0, ST_COOLDOWN=1'b1);
  - default WIDTH, PRESCALE and RELOAD constants, reused by the other tank timers.
- Sub-module tick_prescaler. Ports: clock, reset, enable, clear; output tick = enable && prescaler==PRESCALE-1. It owns the prescaler counter.
- FSM, count and reload register stay in fire_cooldown_timer.

Test Plan:
All scenarios use WIDTH=5, PRESCALE=2, RELOAD=3.
1. Reset/idle: hold reset=0 for 2 cycles -> count=0, ready=1, fire_grant=0, expired=0. Release with enable=1, fire_req=0 -> outputs unchanged for 10 cycles.
2. Single fire: enable=1, fire_req=1 for one edge:
   - grant edge: fire_grant=1 for 1 cycle, count=3, ready=0;
   - count=2 at +2 edges, 1 at +4;
   - 0 at +6 with expired=1 for one cycle and ready=1.
3. Held fire_req: fire_req=1 continuously for 20 cycles -> fire_grant pulses exactly 7 clocks apart; no grant while ready=0.
4. Freeze and async reset:
   - enable=0 for 4 cycles at count=2 -> count and prescaler frozen; expired arrives exactly 4 cycles later than in scenario 2.
   - Later, reset=0 mid-cooldown at count=2 -> count=0 and ready=1 before the next clock edge.
5. Reload rules:
   - load=1, reload_value=31 during cooldown -> current cooldown still ends per scenario 2; next fire gives count=31.
   - load=1, reload_value=5 on the same edge as an accepted fire -> count=5.
   - reload_value=0 loaded, then fire -> fire_grant=1, ready stays 1, count=0, no expired pulse.
